// File: rtl/dccm_sram_ctrl.sv
// Data-memory responder: one load/store at a time onto a single-port
// 32-bit SRAM macro, with sub-word load extension and store RMW.
module dccm_sram_ctrl #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 16,
  parameter int SramAddrW = 14
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [2:0]           byte_en,
  input  logic [AddrWidth-1:0] address,
  input  logic [DataWidth-1:0] data_in,
  output logic [DataWidth-1:0] data_out,
  output logic                 done,
  output logic                 err,
  output logic                 stall,
  output logic                 sram_csb,
  output logic                 sram_web,
  output logic                 sram_oeb,
  output logic [SramAddrW-1:0] sram_addr,
  output logic [DataWidth-1:0] sram_wdata,
  input  logic [DataWidth-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    IDLE, ERR, RD, RESP, WR, RMW_RD, MERGE, RMW_WR
  } state_t;

  state_t state, nxt;

  logic                 req;
  logic                 mis;
  logic                 bad;
  logic [1:0]           sz_q;
  logic [1:0]           lane_q;
  logic                 zx_q;
  logic [15:0]          wd_q;
  logic [DataWidth-1:0] dout_q;
  logic [DataWidth-1:0] rd_ext;
  logic [DataWidth-1:0] mrg;
  logic [7:0]           rb;
  logic [15:0]          rh;

  assign req = read_en | write_en;

  always_comb begin
    mis = 1'b0;
    unique case (byte_en[1:0])
      2'b01:   mis = address[0];
      2'b10:   mis = |address[1:0];
      default: mis = 1'b0;
    endcase
    bad = (read_en & write_en) | (&byte_en[1:0]) | mis;
  end

  always_ff @(posedge brq_clk) begin
    if (brq_rst) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (bad)                       nxt = ERR;
          else if (read_en)              nxt = RD;
          else if (byte_en[1:0] == 2'b10) nxt = WR;
          else                           nxt = RMW_RD;
        end
      end
      ERR:     nxt = IDLE;
      RD:      nxt = RESP;
      RESP:    nxt = IDLE;
      WR:      nxt = IDLE;
      RMW_RD:  nxt = MERGE;
      MERGE:   nxt = RMW_WR;
      RMW_WR:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Macro pins are registered from the next state so they never glitch.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_oeb   <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      dout_q     <= '0;
      sz_q       <= '0;
      lane_q     <= '0;
      zx_q       <= 1'b0;
      wd_q       <= '0;
    end else begin
      sram_csb <= !(nxt inside {RD, WR, RMW_RD, RMW_WR});
      sram_web <= !(nxt inside {WR, RMW_WR});
      sram_oeb <= !(nxt inside {RD, RMW_RD});
      if (state == IDLE && req) begin
        sz_q   <= byte_en[1:0];
        zx_q   <= byte_en[2];
        lane_q <= address[1:0];
        wd_q   <= data_in[15:0];
        if (!bad) sram_addr <= address[AddrWidth-1:2];
      end
      if (nxt == WR)      sram_wdata <= data_in;
      if (state == MERGE) sram_wdata <= mrg;
      if (state == RESP)  dout_q     <= rd_ext;
    end
  end

  always_comb begin
    rb = sram_rdata[{lane_q, 3'b000} +: 8];
    rh = lane_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    unique case (sz_q)
      2'b00: rd_ext = zx_q ? {{(DataWidth-8){1'b0}}, rb}
                           : {{(DataWidth-8){rb[7]}}, rb};
      2'b01: rd_ext = zx_q ? {{(DataWidth-16){1'b0}}, rh}
                           : {{(DataWidth-16){rh[15]}}, rh};
      default: rd_ext = sram_rdata;
    endcase
    mrg = sram_rdata;
    if (sz_q == 2'b00)  mrg[{lane_q, 3'b000} +: 8] = wd_q[7:0];
    else if (lane_q[1]) mrg[31:16] = wd_q;
    else                mrg[15:0]  = wd_q;
  end

  always_comb begin
    done     = 1'b0;
    err      = 1'b0;
    stall    = 1'b0;
    data_out = dout_q;
    unique case (state)
      IDLE: stall = req;
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      RESP: begin
        done     = 1'b1;
        data_out = rd_ext;
      end
      WR, RMW_WR: done = 1'b1;
      default: stall = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dccm_sram_ctrl.sv
// Bench for dccm_sram_ctrl: SRAM macro model, byte-level reference
// memory, per-cycle compare process and directed/random stimulus.
module tb_dccm_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [2:0]  byte_en = '0;
  logic [15:0] address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        done, err, stall;
  logic        sram_csb, sram_web, sram_oeb;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;

  logic [31:0] mem [0:16383] = '{default: 32'h0};
  logic [7:0]  ref_b [0:65535] = '{default: 8'h0};

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  dccm_sram_ctrl dut (
    .brq_clk(clk), .brq_rst(rst),
    .read_en(read_en), .write_en(write_en),
    .byte_en(byte_en), .address(address),
    .data_in(data_in), .data_out(data_out),
    .done(done), .err(err), .stall(stall),
    .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_oeb(sram_oeb), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_wdata;
      if (!sram_oeb) sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ld_val(input logic [15:0] a,
      input logic [1:0] sz, input logic zx);
    logic [31:0] v;
    int n;
    v = '0;
    n = 1 << sz;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
    if (!zx && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!zx && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [31:0] st_word(input logic [15:0] a,
      input logic [1:0] sz, input logic [31:0] d);
    logic [7:0] b [4];
    int base;
    int n;
    base = int'(a) & 32'hFFFC;
    n = 1 << sz;
    for (int k = 0; k < 4; k++) b[k] = ref_b[base + k];
    for (int i = 0; i < n; i++) b[int'(a[1:0]) + i] = d[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic st_apply(input logic [15:0] a, input logic [1:0] sz,
                          input logic [31:0] d);
    for (int i = 0; i < (1 << sz); i++)
      ref_b[int'(a) + i] = d[8*i +: 8];
  endtask

  bit          pending = 1'b0;
  int          ph, m_lat;
  bit          m_r, m_err, e_done, acc_rd, acc_wr;
  logic [1:0]  m_sz;
  logic [15:0] m_a;
  logic [31:0] m_d, m_ld, m_ww, exp_do;
  logic [31:0] last_dout = '0;

  always @(negedge clk) begin
    if (rst) begin
      // a write already on the pins lands at the reset edge
      if (pending && !m_err && !m_r && ph == m_lat)
        st_apply(m_a, m_sz, m_d);
      pending = 1'b0;
      last_dout = '0;
    end else if (chk_on) begin
      if (!pending && (read_en || write_en)) begin
        pending = 1'b1;
        ph = 0;
        m_r = read_en;
        m_sz = byte_en[1:0];
        m_a = address;
        m_d = data_in;
        m_err = (read_en && write_en) || m_sz == 2'd3 ||
                (m_sz == 2'd1 && address[0]) ||
                (m_sz == 2'd2 && address[1:0] != 2'd0);
        m_lat = m_err ? 1 : m_r ? 2 : (m_sz == 2'd2) ? 1 : 3;
        if (!m_err) begin
          m_ld = ld_val(address, m_sz, byte_en[2]);
          m_ww = st_word(address, m_sz, data_in);
        end
      end
      e_done = pending && ph == m_lat;
      acc_rd = pending && !m_err && ph == 1 && (m_r || m_sz != 2'd2);
      acc_wr = pending && !m_err && !m_r &&
               ((m_sz == 2'd2 && ph == 1) || (m_sz != 2'd2 && ph == 3));
      chk("stall", stall, pending && ph < m_lat);
      chk("done", done, e_done);
      chk("err", err, e_done && m_err);
      chk("csb", sram_csb, !(acc_rd || acc_wr));
      chk("oeb", sram_oeb, !acc_rd);
      chk("web", sram_web, !acc_wr);
      chk("web_oeb_excl", sram_web | sram_oeb, 1);
      if (acc_rd || acc_wr) chk("sram_addr", sram_addr, m_a >> 2);
      if (acc_wr) chk("sram_wdata", sram_wdata, m_ww);
      exp_do = (e_done && m_r && !m_err) ? m_ld : last_dout;
      chk("data_out", data_out, exp_do);
      last_dout = exp_do;
      if (e_done) begin
        if (!m_r && !m_err) st_apply(m_a, m_sz, m_d);
        pending = 1'b0;
      end else if (pending) begin
        ph++;
      end
    end
  end

  task automatic op(input bit r, input bit w, input logic [2:0] be,
      input logic [15:0] a, input logic [31:0] d,
      output int lat, output logic [31:0] q, output bit e);
    @(posedge clk);
    #1;
    read_en = r;
    write_en = w;
    byte_en = be;
    address = a;
    data_in = d;
    lat = 0;
    @(negedge clk);
    while (!done) begin
      lat++;
      if (lat > 8) begin
        total++;
        bad++;
        $display("FAIL op_timeout done=%b want=1", done);
        break;
      end
      @(negedge clk);
    end
    q = data_out;
    e = err;
  endtask

  task automatic gap(input int n);
    @(posedge clk);
    #1;
    read_en = 1'b0;
    write_en = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    int          lat;
    logic [31:0] q;
    bit          e;
    int          k;
    bit          r, w;
    logic [1:0]  sz;
    logic [15:0] a;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb", sram_csb, 1);
    chk("rst_web", sram_web, 1);
    chk("rst_oeb", sram_oeb, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    chk_on = 1'b1;

    op(0, 1, 3'b010, 16'h0010, 32'hDEADBEEF, lat, q, e);
    chk("t1_sw_lat", lat, 1);
    op(1, 0, 3'b010, 16'h0010, 32'h0, lat, q, e);
    chk("t1_lw_lat", lat, 2);
    chk("t1_lw_data", q, 32'hDEADBEEF);
    chk("t1_mem", mem[4], 32'hDEADBEEF);

    op(1, 0, 3'b000, 16'h0013, 32'h0, lat, q, e);
    chk("t2_lb", q, 32'hFFFFFFDE);
    op(1, 0, 3'b100, 16'h0013, 32'h0, lat, q, e);
    chk("t2_lbu", q, 32'h000000DE);
    op(1, 0, 3'b001, 16'h0012, 32'h0, lat, q, e);
    chk("t2_lh", q, 32'hFFFFDEAD);
    op(1, 0, 3'b101, 16'h0010, 32'h0, lat, q, e);
    chk("t2_lhu", q, 32'h0000BEEF);

    op(0, 1, 3'b000, 16'h0011, 32'h55, lat, q, e);
    chk("t3_sb_lat", lat, 3);
    gap(1);
    chk("t3_sb_mem", mem[4], 32'hDEAD55EF);
    op(0, 1, 3'b001, 16'h0012, 32'h1234, lat, q, e);
    chk("t3_sh_lat", lat, 3);
    gap(1);
    chk("t3_sh_mem", mem[4], 32'h123455EF);

    op(1, 0, 3'b010, 16'h0012, 32'h0, lat, q, e);
    chk("t4_lw_mis_lat", lat, 1);
    chk("t4_lw_mis_err", e, 1);
    op(0, 1, 3'b001, 16'h0011, 32'hFFFF, lat, q, e);
    chk("t4_sh_mis_lat", lat, 1);
    chk("t4_sh_mis_err", e, 1);
    op(1, 1, 3'b010, 16'h0010, 32'h0, lat, q, e);
    chk("t4_rw_lat", lat, 1);
    chk("t4_rw_err", e, 1);
    chk("t4_dout_hold", q, 32'h0000BEEF);
    gap(1);
    chk("t4_mem", mem[4], 32'h123455EF);

    gap(2);
    @(posedge clk);
    #1;
    write_en = 1'b1;
    byte_en = 3'b000;
    address = 16'h0011;
    data_in = 32'hAA;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    write_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5a_csb", sram_csb, 1);
    chk("t5a_web", sram_web, 1);
    chk("t5a_oeb", sram_oeb, 1);
    chk("t5a_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5a_mem", mem[4], 32'h123455EF);

    @(posedge clk);
    #1;
    write_en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t5b_web_low", sram_web, 0);
    rst = 1'b1;
    write_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5b_csb", sram_csb, 1);
    chk("t5b_mem", mem[4], 32'h1234AAEF);

    for (int i = 0; i < 400; i++) begin
      k = int'($urandom % 20);
      r = (k < 8) || (k == 19);
      w = (k >= 8);
      sz = ($urandom % 25 == 0) ? 2'd3 : 2'($urandom % 3);
      a = 16'($urandom % 64);
      if ($urandom % 8 != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      op(r, w, {1'($urandom % 2), sz}, a, $urandom, lat, q, e);
      if ($urandom % 3 == 0) gap(int'($urandom_range(1, 3)));
    end
    gap(3);

    for (int wi = 0; wi < 16; wi++)
      chk("final_mem", mem[wi],
          {ref_b[4*wi+3], ref_b[4*wi+2], ref_b[4*wi+1], ref_b[4*wi]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
